vdc_ramctl: RTL and testbench

Access controller for the VDC single-port video RAM. It shares the single RAM port between three requesters under fixed priority: display fetch, CPU data-register access, and the block copy/fill engine. The block copy/fill engine is contained in this block. It sits between the VDC register file / display pipeline and the video RAM instance, and drives that RAM's `rd`, `we`, `addr` and `dai` directly.

---
 rtl/vdc_ramctl.sv | 188 ++++++++++++++++++
 tb/tb_vdc_ramctl.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdc_ramctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vdc_ramctl : single-port video RAM arbiter (display > CPU > block engine) |
// |              with built-in block copy/fill engine.                       |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module vdc_ramctl #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     disp_req,
  input  logic [ADDRESS_WIDTH-1:0] disp_addr,
  output logic                     disp_ack,
  output logic                     disp_valid,
  output logic [DATA_WIDTH-1:0]    disp_data,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic                     cpu_busy,
  output logic                     cpu_done,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  input  logic                     blk_start,
  input  logic                     blk_copy,
  input  logic [ADDRESS_WIDTH-1:0] blk_src,
  input  logic [ADDRESS_WIDTH-1:0] blk_dst,
  input  logic [7:0]               blk_count,
  input  logic [DATA_WIDTH-1:0]    blk_fill,
  output logic                     blk_busy,
  output logic                     blk_done,
  output logic [ADDRESS_WIDTH-1:0] blk_src_nxt,
  output logic [ADDRESS_WIDTH-1:0] blk_dst_nxt,
  output logic                     ram_rd,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dai,
  input  logic [DATA_WIDTH-1:0]    ram_dao
);

  localparam logic [ADDRESS_WIDTH-1:0] c_addr_one = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic                     r_cpu_busy, r_cpu_we, r_cpu_done, r_cpu_rd;
  logic [ADDRESS_WIDTH-1:0] r_cpu_addr;
  logic [DATA_WIDTH-1:0]    r_cpu_wdata, r_cpu_rdata;
  logic                     r_disp_valid;
  logic                     r_copy, r_rdpend, r_blk_done;
  logic [ADDRESS_WIDTH-1:0] r_src, r_dst, r_last_addr;
  logic [8:0]               r_cnt;
  logic [DATA_WIDTH-1:0]    r_cbuf;

  logic                     w_cpu_gnt, w_blk_gnt, w_blk_rd, w_blk_wr, w_last;
  logic [DATA_WIDTH-1:0]    w_blk_wdata;

  assign w_cpu_gnt   = r_cpu_busy & ~disp_req;
  assign w_blk_gnt   = (r_state != IDLE) & ~disp_req & ~r_cpu_busy;
  assign w_blk_rd    = w_blk_gnt & (r_state == RD);
  assign w_blk_wr    = w_blk_gnt & (r_state == WR);
  assign w_last      = (r_cnt == 9'd1);
  // Copy data comes straight off the RAM when the read just landed, else from the buffer.
  assign w_blk_wdata = r_copy ? (r_rdpend ? ram_dao : r_cbuf) : blk_fill;

  assign disp_ack    = disp_req;
  assign disp_valid  = r_disp_valid;
  assign disp_data   = ram_dao;
  assign cpu_busy    = r_cpu_busy;
  assign cpu_done    = r_cpu_done;
  assign cpu_rdata   = r_cpu_rd ? ram_dao : r_cpu_rdata;
  assign blk_busy    = (r_state != IDLE);
  assign blk_done    = r_blk_done;
  assign blk_src_nxt = r_src;
  assign blk_dst_nxt = r_dst;

  always_comb begin
    ram_rd   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = r_last_addr;
    ram_dai  = '0;
    if (disp_req) begin
      ram_rd   = 1'b1;
      ram_addr = disp_addr;
    end else if (w_cpu_gnt) begin
      ram_rd   = ~r_cpu_we;
      ram_we   = r_cpu_we;
      ram_addr = r_cpu_addr;
      ram_dai  = r_cpu_wdata;
    end else if (w_blk_rd) begin
      ram_rd   = 1'b1;
      ram_addr = r_src;
    end else if (w_blk_wr) begin
      ram_we   = 1'b1;
      ram_addr = r_dst;
      ram_dai  = w_blk_wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (blk_start) w_state_nxt = blk_copy ? RD : WR;
      RD:   if (w_blk_gnt) w_state_nxt = WR;
      WR: begin
        if (w_blk_gnt) begin
          if (w_last) w_state_nxt = IDLE;
          else        w_state_nxt = r_copy ? RD : WR;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cpu_busy   <= 1'b0;
      r_cpu_we     <= 1'b0;
      r_cpu_addr   <= '0;
      r_cpu_wdata  <= '0;
      r_cpu_done   <= 1'b0;
      r_cpu_rd     <= 1'b0;
      r_cpu_rdata  <= '0;
      r_disp_valid <= 1'b0;
      r_last_addr  <= '0;
    end else begin
      r_disp_valid <= disp_req;
      r_last_addr  <= ram_addr;
      r_cpu_done   <= w_cpu_gnt;
      r_cpu_rd     <= w_cpu_gnt & ~r_cpu_we;
      if (r_cpu_rd) r_cpu_rdata <= ram_dao;
      if (w_cpu_gnt) r_cpu_busy <= 1'b0;
      if (cpu_req && !r_cpu_busy) begin
        r_cpu_busy  <= 1'b1;
        r_cpu_we    <= cpu_we;
        r_cpu_addr  <= cpu_addr;
        r_cpu_wdata <= cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_copy     <= 1'b0;
      r_src      <= '0;
      r_dst      <= '0;
      r_cnt      <= '0;
      r_rdpend   <= 1'b0;
      r_cbuf     <= '0;
      r_blk_done <= 1'b0;
    end else begin
      r_blk_done <= w_blk_wr & w_last;
      if (r_rdpend) begin
        r_cbuf   <= ram_dao;
        r_rdpend <= 1'b0;
      end
      if (r_state == IDLE && blk_start) begin
        r_copy <= blk_copy;
        r_src  <= blk_src;
        r_dst  <= blk_dst;
        r_cnt  <= (blk_count == 8'd0) ? 9'd256 : {1'b0, blk_count};
      end
      if (w_blk_rd) begin
        r_src    <= r_src + c_addr_one;
        r_rdpend <= 1'b1;
      end
      if (w_blk_wr) begin
        r_dst <= r_dst + c_addr_one;
        r_cnt <= r_cnt - 9'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vdc_ramctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vdc_ramctl : self-checking bench for vdc_ramctl with a behavioural RAM |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_vdc_ramctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        disp_req, disp_ack, disp_valid;
  logic [15:0] disp_addr;
  logic [7:0]  disp_data;
  logic        cpu_req, cpu_we, cpu_busy, cpu_done;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        blk_start, blk_copy, blk_busy, blk_done;
  logic [15:0] blk_src, blk_dst, blk_src_nxt, blk_dst_nxt;
  logic [7:0]  blk_count, blk_fill;
  logic        ram_rd, ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dai, ram_dao;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  vdc_ramctl #(.ADDRESS_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .blk_start(blk_start), .blk_copy(blk_copy), .blk_src(blk_src), .blk_dst(blk_dst),
    .blk_count(blk_count), .blk_fill(blk_fill), .blk_busy(blk_busy), .blk_done(blk_done),
    .blk_src_nxt(blk_src_nxt), .blk_dst_nxt(blk_dst_nxt),
    .ram_rd(ram_rd), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dai(ram_dai),
    .ram_dao(ram_dao)
  );

  // Synchronous single-port RAM; the preload port lets the bench seed contents.
  logic [7:0]  mem [0:65535];
  logic [7:0]  dao_q;
  logic        pl_we = 1'b0;
  logic [15:0] pl_addr = 16'h0;
  logic [7:0]  pl_data = 8'h0;
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr] <= ram_dai;
    if (ram_rd) dao_q <= mem[ram_addr];
  end
  assign ram_dao = dao_q;

  // Reference memory: what the RAM should hold by the rules of each operation.
  logic [7:0] ref_mem [0:65535];

  typedef struct {
    logic        we;
    logic [15:0] a;
    logic [7:0]  d;
  } cpu_op_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_req = 0; disp_addr = 16'h0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    blk_start = 0; blk_copy = 0; blk_src = 16'h0; blk_dst = 16'h0;
    blk_count = 8'h0; blk_fill = 8'h0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d; ref_mem[a] = d;
    step();
    pl_we = 1'b0;
  endtask

  task automatic ref_block(input logic copy, input logic [15:0] src, input logic [15:0] dst,
                           input int n, input logic [7:0] fill);
    for (int i = 0; i < n; i++) begin
      if (copy) ref_mem[16'(dst + i)] = ref_mem[16'(src + i)];
      else      ref_mem[16'(dst + i)] = fill;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    step(); step();
    @(negedge clk);
    n_cmp++;
    if ({cpu_busy, blk_busy, disp_valid, cpu_done, blk_done, ram_rd, ram_we, disp_ack} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, want 00000000",
               {cpu_busy, blk_busy, disp_valid, cpu_done, blk_done, ram_rd, ram_we, disp_ack});
    end
    n_cmp++;
    if ({cpu_rdata, blk_src_nxt, blk_dst_nxt, ram_addr} !== 56'h0) begin
      n_bad++;
      $display("FAIL reset_data: rdata=%h src=%h dst=%h addr=%h, want all zero",
               cpu_rdata, blk_src_nxt, blk_dst_nxt, ram_addr);
    end
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_fill();
    logic [15:0] exp_addr;
    logic        exp_we, exp_done;
    for (int k = 0; k <= 5; k++) begin
      step();
      if (k == 0) begin
        blk_start = 1; blk_copy = 0; blk_dst = 16'h0800; blk_count = 8'd4; blk_fill = 8'h20;
      end else blk_start = 0;
      @(negedge clk);
      exp_we   = (k >= 1 && k <= 4);
      exp_addr = 16'(16'h0800 + k - 1);
      exp_done = (k == 5);
      n_cmp++;
      if (ram_we !== exp_we || (exp_we && (ram_addr !== exp_addr || ram_dai !== 8'h20))) begin
        n_bad++;
        $display("FAIL fill_write k=%0d: we=%b addr=%h dai=%h, want we=%b addr=%h dai=20",
                 k, ram_we, ram_addr, ram_dai, exp_we, exp_addr);
      end
      n_cmp++;
      if (blk_done !== exp_done) begin
        n_bad++;
        $display("FAIL fill_done k=%0d: got %b want %b", k, blk_done, exp_done);
      end
    end
    ref_block(1'b0, 16'h0, 16'h0800, 4, 8'h20);
    n_cmp++;
    if (blk_dst_nxt !== 16'h0804 || blk_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_end: dst_nxt=%h busy=%b, want 0804 0", blk_dst_nxt, blk_busy);
    end
    n_cmp++;
    if ({mem[16'h0800], mem[16'h0801], mem[16'h0802], mem[16'h0803]} !== 32'h20202020) begin
      n_bad++;
      $display("FAIL fill_mem: got %h%h%h%h want 20202020",
               mem[16'h0800], mem[16'h0801], mem[16'h0802], mem[16'h0803]);
    end
  endtask

  task automatic test_copy_wrap();
    int n0, done_cyc;
    poke(16'hFFFE, 8'h11); poke(16'hFFFF, 8'h22); poke(16'h0000, 8'h33);
    step();
    blk_start = 1; blk_copy = 1; blk_src = 16'hFFFE; blk_dst = 16'h1000; blk_count = 8'd3;
    n0 = cyc;
    done_cyc = -1;
    ref_block(1'b1, 16'hFFFE, 16'h1000, 3, 8'h00);
    for (int k = 0; k < 40 && done_cyc < 0; k++) begin
      if (k > 0) begin step(); blk_start = 0; end
      @(negedge clk);
      if (blk_done) done_cyc = cyc;
    end
    n_cmp++;
    if (done_cyc != n0 + 7) begin
      n_bad++;
      $display("FAIL copy_done_time: done at N+%0d, want N+7", done_cyc - n0);
    end
    n_cmp++;
    if ({mem[16'h1000], mem[16'h1001], mem[16'h1002]} !== 24'h112233) begin
      n_bad++;
      $display("FAIL copy_wrap_mem: got %h%h%h want 112233",
               mem[16'h1000], mem[16'h1001], mem[16'h1002]);
    end
    n_cmp++;
    if (blk_src_nxt !== 16'h0001 || blk_dst_nxt !== 16'h1003) begin
      n_bad++;
      $display("FAIL copy_wrap_ptr: src=%h dst=%h want 0001 1003", blk_src_nxt, blk_dst_nxt);
    end
    step();
    blk_start = 0;
  endtask

  task automatic test_copy_preempt();
    int          pre_left, n_pre, bad;
    logic        prev_disp, done;
    logic [15:0] prev_addr;
    for (int i = 0; i < 4; i++) poke(16'(16'h3000 + i), 8'($urandom));
    for (int i = 0; i < 8; i++) poke(16'(16'h5000 + i), 8'($urandom));
    ref_block(1'b1, 16'h3000, 16'h3100, 4, 8'h00);
    pre_left = 0; n_pre = 0; prev_disp = 0; prev_addr = 16'h0; done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      step();
      blk_start = (k == 0); blk_copy = 1; blk_src = 16'h3000; blk_dst = 16'h3100; blk_count = 8'd4;
      disp_req = (pre_left > 0);
      if (disp_req) begin
        disp_addr = 16'(16'h5000 + $urandom_range(0, 7));
        pre_left--;
        n_pre++;
      end
      @(negedge clk);
      if (prev_disp) begin
        n_cmp++;
        if (disp_valid !== 1'b1 || disp_data !== ref_mem[prev_addr]) begin
          n_bad++;
          $display("FAIL preempt_disp: valid=%b data=%h want 1 %h (addr %h)",
                   disp_valid, disp_data, ref_mem[prev_addr], prev_addr);
        end
      end
      if (disp_req) begin
        n_cmp++;
        if (disp_ack !== 1'b1 || ram_rd !== 1'b1 || ram_we !== 1'b0 || ram_addr !== disp_addr) begin
          n_bad++;
          $display("FAIL preempt_ack: ack=%b rd=%b we=%b addr=%h want 1 1 0 %h",
                   disp_ack, ram_rd, ram_we, ram_addr, disp_addr);
        end
      end else if (ram_rd && ram_addr >= 16'h3000 && ram_addr < 16'h3004) begin
        pre_left = 3;
      end
      prev_disp = disp_req;
      prev_addr = disp_addr;
      if (blk_done) done = 1;
    end
    disp_req = 0;
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL preempt_timeout: blk_done not seen, want done within 100 cycles");
    end
    n_cmp++;
    if (n_pre != 12) begin
      n_bad++;
      $display("FAIL preempt_count: %0d display cycles inserted, want 12", n_pre);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) if (mem[16'(16'h3100 + i)] !== ref_mem[16'(16'h3100 + i)]) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL preempt_mem: %0d destination bytes wrong, want 0", bad);
    end
  endtask

  task automatic test_cpu_contention();
    int   n0, eng_wr, done_cyc, bad;
    logic exp_cpu;
    step();
    n0 = cyc; eng_wr = 0; done_cyc = -1;
    blk_start = 1; blk_copy = 0; blk_dst = 16'h1F80; blk_count = 8'd0; blk_fill = 8'h5A;
    for (int k = 0; k < 600 && done_cyc < 0; k++) begin
      if (k > 0) step();
      if (k > 0) blk_start = 0;
      cpu_req   = (k == 3 || k == 10);
      cpu_we    = 1;
      cpu_wdata = 8'hA5;
      cpu_addr  = (k == 3) ? 16'h2000 : 16'h4000;
      @(negedge clk);
      exp_cpu = (k == 4 || k == 11);
      if (exp_cpu) begin
        n_cmp++;
        if (ram_we !== 1'b1 || ram_dai !== 8'hA5 || ram_addr !== ((k == 4) ? 16'h2000 : 16'h4000)) begin
          n_bad++;
          $display("FAIL cont_cpu_grant k=%0d: we=%b addr=%h dai=%h want CPU write A5", k, ram_we, ram_addr, ram_dai);
        end
      end else if (ram_we) eng_wr++;
      if (k == 5 || k == 12) begin
        n_cmp++;
        if (cpu_done !== 1'b1) begin
          n_bad++;
          $display("FAIL cont_cpu_done k=%0d: got %b want 1", k, cpu_done);
        end
      end
      if (blk_done) done_cyc = cyc;
    end
    cpu_req = 0;
    ref_block(1'b0, 16'h0, 16'h1F80, 256, 8'h5A);
    ref_mem[16'h4000] = 8'hA5;
    n_cmp++;
    if (done_cyc != n0 + 259 || eng_wr != 256) begin
      n_bad++;
      $display("FAIL cont_fill: done at N+%0d with %0d writes, want N+259 with 256", done_cyc - n0, eng_wr);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[16'(16'h1F80 + i)] !== ref_mem[16'(16'h1F80 + i)]) bad++;
    n_cmp++;
    if (bad != 0 || mem[16'h4000] !== 8'hA5 || blk_dst_nxt !== 16'h2080) begin
      n_bad++;
      $display("FAIL cont_mem: %0d fill bytes wrong, 4000=%h dst_nxt=%h, want 0 A5 2080",
               bad, mem[16'h4000], blk_dst_nxt);
    end
  endtask

  task automatic test_dropped();
    int n_done, done_k;
    poke(16'h6000, 8'h00); poke(16'h6001, 8'h00);
    n_done = 0; done_k = -1;
    for (int k = 0; k < 10; k++) begin
      step();
      cpu_req  = (k == 0 || k == 1);
      cpu_we   = 1;
      cpu_addr = (k == 0) ? 16'h6000 : 16'h6001;
      cpu_wdata = (k == 0) ? 8'h33 : 8'h44;
      disp_req = (k == 1);
      disp_addr = 16'h5000;
      @(negedge clk);
      if (k == 1) begin
        n_cmp++;
        if (cpu_busy !== 1'b1 || ram_we !== 1'b0) begin
          n_bad++;
          $display("FAIL drop_busy: busy=%b we=%b want 1 0", cpu_busy, ram_we);
        end
      end
      if (cpu_done) begin n_done++; done_k = k; end
    end
    cpu_req = 0; disp_req = 0;
    ref_mem[16'h6000] = 8'h33;
    n_cmp++;
    if (n_done != 1 || done_k != 3) begin
      n_bad++;
      $display("FAIL drop_done: %0d done pulses, last at k=%0d, want 1 at k=3", n_done, done_k);
    end
    n_cmp++;
    if (mem[16'h6000] !== 8'h33 || mem[16'h6001] !== 8'h00) begin
      n_bad++;
      $display("FAIL drop_mem: 6000=%h 6001=%h want 33 00", mem[16'h6000], mem[16'h6001]);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      cpu_req = (k == 0); cpu_we = 0; cpu_addr = 16'h4000;
      @(negedge clk);
      if (k == 2) begin
        n_cmp++;
        if (cpu_done !== 1'b1 || cpu_rdata !== 8'hA5) begin
          n_bad++;
          $display("FAIL cpu_read: done=%b rdata=%h want 1 A5", cpu_done, cpu_rdata);
        end
      end
    end
    cpu_req = 0;
  endtask

  task automatic test_random();
    cpu_op_t     q[$];
    cpu_op_t     op;
    logic        prev_disp, done, cp;
    logic [15:0] prev_addr, src, dst;
    logic [7:0]  cnt8, fill;
    int          n, bad;
    for (int i = 0; i < 16'h0300; i++) poke(16'(i), 8'($urandom));
    for (int i = 0; i < 64; i++) poke(16'(16'h0400 + i), 8'($urandom));
    for (int i = 0; i < 64; i++) poke(16'(16'h0500 + i), 8'($urandom));
    for (int r = 0; r < 6; r++) begin
      cp   = 1'($urandom);
      src  = 16'($urandom_range(0, 16'h0200));
      dst  = 16'($urandom_range(0, 16'h0200));
      cnt8 = 8'($urandom);
      fill = 8'($urandom);
      n    = (cnt8 == 0) ? 256 : int'(cnt8);
      ref_block(cp, src, dst, n, fill);
      prev_disp = 0; prev_addr = 16'h0; done = 0;
      for (int k = 0; k < 5000 && !(done && q.size() == 0); k++) begin
        step();
        blk_start = (k == 0); blk_copy = cp; blk_src = src; blk_dst = dst;
        blk_count = cnt8; blk_fill = fill;
        disp_req  = ($urandom_range(0, 99) < 30);
        disp_addr = 16'(16'h0400 + $urandom_range(0, 63));
        cpu_req   = 0;
        if (!cpu_busy && $urandom_range(0, 99) < 20) begin
          cpu_req   = 1;
          cpu_we    = 1'($urandom);
          cpu_addr  = 16'(16'h0500 + $urandom_range(0, 63));
          cpu_wdata = 8'($urandom);
          if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
          op.we = cpu_we; op.a = cpu_addr; op.d = ref_mem[cpu_addr];
          q.push_back(op);
        end
        @(negedge clk);
        n_cmp++;
        if (disp_valid !== prev_disp || (prev_disp && disp_data !== ref_mem[prev_addr])) begin
          n_bad++;
          $display("FAIL rnd_disp: valid=%b data=%h want %b %h", disp_valid, disp_data,
                   prev_disp, ref_mem[prev_addr]);
        end
        if (cpu_done) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL rnd_cpu_done: unexpected pulse, want no pulse");
          end else begin
            op = q.pop_front();
            if (!op.we && cpu_rdata !== op.d) begin
              n_bad++;
              $display("FAIL rnd_cpu_read: addr=%h got %h want %h", op.a, cpu_rdata, op.d);
            end
          end
        end
        prev_disp = disp_req;
        prev_addr = disp_addr;
        if (blk_done) done = 1;
      end
      idle_inputs();
      step();
      n_cmp++;
      if (!done || q.size() != 0) begin
        n_bad++;
        $display("FAIL rnd_timeout op=%0d: done=%b pending=%0d, want 1 0", r, done, q.size());
        q.delete();
      end
      bad = 0;
      for (int i = 0; i < 16'h0600; i++) if (mem[16'(i)] !== ref_mem[16'(i)]) bad++;
      n_cmp++;
      if (bad != 0 || blk_dst_nxt !== 16'(dst + n) || blk_src_nxt !== (cp ? 16'(src + n) : src)) begin
        n_bad++;
        $display("FAIL rnd_block op=%0d: %0d bytes wrong, src_nxt=%h dst_nxt=%h, want 0 %h %h",
                 r, bad, blk_src_nxt, blk_dst_nxt, cp ? 16'(src + n) : src, 16'(dst + n));
      end
    end
  endtask

  task automatic test_reset_midcopy();
    for (int k = 0; k <= 7; k++) begin
      step();
      blk_start = (k == 0); blk_copy = 1; blk_src = 16'h0000; blk_dst = 16'h0100; blk_count = 8'd8;
    end
    n_cmp++;
    if (blk_busy !== 1'b1 || blk_dst_nxt !== 16'h0103) begin
      n_bad++;
      $display("FAIL midcopy_pre: busy=%b dst_nxt=%h want 1 0103", blk_busy, blk_dst_nxt);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({cpu_busy, blk_busy, disp_valid, cpu_done, blk_done, ram_rd, ram_we} !== 7'h00 ||
        {cpu_rdata, blk_src_nxt, blk_dst_nxt} !== 40'h0) begin
      n_bad++;
      $display("FAIL midcopy_reset: flags=%b rdata=%h src=%h dst=%h want all zero",
               {cpu_busy, blk_busy, disp_valid, cpu_done, blk_done, ram_rd, ram_we},
               cpu_rdata, blk_src_nxt, blk_dst_nxt);
    end
    blk_start = 0;
    step(); step();
    reset_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      @(negedge clk);
      n_cmp++;
      if ({ram_rd, ram_we, blk_busy} !== 3'b000) begin
        n_bad++;
        $display("FAIL midcopy_after k=%0d: rd=%b we=%b busy=%b want 000", k, ram_rd, ram_we, blk_busy);
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_copy_wrap();
    test_copy_preempt();
    test_cpu_contention();
    test_dropped();
    test_random();
    test_reset_midcopy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
